// File: rtl/uart_hex_echo_pkg.sv
// Shared constants, FSM state encoding and the nibble-to-ASCII helper for
// the hex echo block.
package uart_hex_echo_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } echo_state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the UART receiver and the echo FSM.
// Registered storage, show-ahead read data (o_rdata is the head entry).
// Ports:
//   i_clk, i_reset (async, active low)
//   i_wr/i_wdata : push request; ignored when full unless a pop happens
//                  on the same edge
//   i_rd         : pop request; ignored when empty
//   o_rdata      : head entry, o_full/o_empty flags, o_count occupancy
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr,
  input  logic [7:0]               i_wdata,
  input  logic                     i_rd,
  output logic [7:0]               o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_en, rd_en;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_rdata = mem[rd_ptr];

  assign rd_en = i_rd & ~o_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en = i_wr & (~o_full | rd_en);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_echo.sv
// Buffers received UART bytes and echoes each as two uppercase hex chars,
// optionally followed by CR LF, through the UART transmitter.
// Ports:
//   i_clk, i_reset (async, active low)
//   i_rx_dv/i_rx_data : receiver byte strobe and data
//   i_tx_busy         : transmitter busy
//   o_tx_dr/o_tx_data : one-cycle transmit strobe and held char
//   o_busy            : FSM active or FIFO non-empty
//   o_overflow        : sticky, a byte was dropped on a full FIFO
//   o_fifo_count      : FIFO occupancy
module uart_hex_echo
  import uart_hex_echo_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int APPEND_CRLF = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_rx_dv,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_tx_busy,
  output logic                          o_tx_dr,
  output logic [7:0]                    o_tx_data,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] LAST_IDX = (APPEND_CRLF != 0) ? 2'd3 : 2'd1;

  echo_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_dr_q, tx_dr_d;
  logic        ovf_q, ovf_d;

  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [7:0]    cur_char;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (i_rx_dv),
    .i_wdata (i_rx_data),
    .i_rd    (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign pop = (state_q == ST_IDLE) & ~fifo_empty;

  always_comb begin
    case (idx_q)
      2'd0:    cur_char = hex_char(byte_q[7:4]);
      2'd1:    cur_char = hex_char(byte_q[3:0]);
      2'd2:    cur_char = ASCII_CR;
      default: cur_char = ASCII_LF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    tx_data_d = tx_data_q;
    tx_dr_d   = 1'b0;
    // Drop only when no pop frees a slot on this edge.
    ovf_d     = ovf_q | (i_rx_dv & fifo_full & ~pop);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          byte_d  = fifo_rdata;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          tx_data_d = cur_char;
          tx_dr_d   = 1'b1;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (i_tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      byte_q    <= 8'h00;
      tx_data_q <= 8'h00;
      tx_dr_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      tx_data_q <= tx_data_d;
      tx_dr_q   <= tx_dr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_tx_dr      = tx_dr_q;
  assign o_tx_data    = tx_data_q;
  assign o_overflow   = ovf_q;
  assign o_fifo_count = fifo_count;
  assign o_busy       = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_hex_echo.sv
module tb_uart_hex_echo;

  logic       gclk = 1'b0;
  logic       grst_n;
  always #5 gclk = ~gclk;

  // DUT 1: depth 4, CR LF appended
  logic       rx_dv, tx_busy, tx_dr, busy, ovf;
  logic [7:0] rx_data, tx_data;
  logic [2:0] cnt;
  // DUT 2: depth 4, hex chars only
  logic       rx_dv2, tx_busy2, tx_dr2, busy2, ovf2, hold2;
  logic [7:0] rx_data2, tx_data2;
  logic [2:0] cnt2;

  int n_chk = 0, n_err = 0;

  uart_hex_echo #(.FIFO_DEPTH(4), .APPEND_CRLF(1)) u_dut (
    .i_clk(gclk), .i_reset(grst_n), .i_rx_dv(rx_dv), .i_rx_data(rx_data),
    .i_tx_busy(tx_busy), .o_tx_dr(tx_dr), .o_tx_data(tx_data),
    .o_busy(busy), .o_overflow(ovf), .o_fifo_count(cnt));

  uart_hex_echo #(.FIFO_DEPTH(4), .APPEND_CRLF(0)) u_dut2 (
    .i_clk(gclk), .i_reset(grst_n), .i_rx_dv(rx_dv2), .i_rx_data(rx_data2),
    .i_tx_busy(tx_busy2), .o_tx_dr(tx_dr2), .o_tx_data(tx_data2),
    .o_busy(busy2), .o_overflow(ovf2), .o_fifo_count(cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter models: busy rises one cycle after the strobe, held 20 cycles.
  logic       bb, bb2;
  logic [4:0] hc, hc2;
  always @(posedge gclk or negedge grst_n)
    if (!grst_n) begin bb <= 0; hc <= 0; end
    else if (tx_dr) begin bb <= 1; hc <= 20; end
    else if (hc != 0) begin hc <= hc - 1; if (hc == 1) bb <= 0; end
  always @(posedge gclk or negedge grst_n)
    if (!grst_n) begin bb2 <= 0; hc2 <= 0; end
    else if (tx_dr2) begin bb2 <= 1; hc2 <= 20; end
    else if (hc2 != 0) begin hc2 <= hc2 - 1; if (hc2 == 1) bb2 <= 0; end
  assign tx_busy  = bb;
  assign tx_busy2 = bb2 | hold2;

  // Capture strobed chars and check the strobe protocol.
  logic [7:0] capq[$], capq2[$];
  logic       need_fall, need_fall2, pbusy, pbusy2;
  always @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      need_fall <= 0; need_fall2 <= 0; pbusy <= 0; pbusy2 <= 0;
    end else begin
      pbusy <= tx_busy; pbusy2 <= tx_busy2;
      if (tx_dr) begin
        capq.push_back(tx_data);
        chk("strobe_while_busy", {31'd0, tx_busy}, 0);
        chk("strobe_no_busy_fall", {31'd0, need_fall}, 0);
        need_fall <= 1;
      end else if (pbusy && !tx_busy) need_fall <= 0;
      if (tx_dr2) begin
        capq2.push_back(tx_data2);
        chk("strobe2_while_busy", {31'd0, tx_busy2}, 0);
        chk("strobe2_no_busy_fall", {31'd0, need_fall2}, 0);
        need_fall2 <= 1;
      end else if (pbusy2 && !tx_busy2) need_fall2 <= 0;
    end
  end

  logic       trk_peak;
  logic [2:0] peak;
  always @(posedge gclk) if (trk_peak && cnt > peak) peak <= cnt;

  // Caller is at a negedge; consecutive calls push on consecutive edges.
  task automatic push(input logic [7:0] b);
    rx_dv = 1; rx_data = b;
    @(negedge gclk);
    rx_dv = 0;
  endtask

  task automatic wait_idle(input string tag, input int which);
    int n = 0;
    while (((which == 1) ? (busy || bb) : (busy2 || tx_busy2)) && n < 3000) begin
      @(negedge gclk); n++;
    end
    chk(tag, {31'd0, n < 3000}, 1);
  endtask

  function automatic void add_hex(inout logic [7:0] q[$], input logic [7:0] b, input bit crlf);
    string hx = "0123456789ABCDEF";
    q.push_back(hx[b[7:4]]);
    q.push_back(hx[b[3:0]]);
    if (crlf) begin q.push_back(8'h0D); q.push_back(8'h0A); end
  endfunction

  task automatic cmp_q(input string tag, input logic [7:0] exp[$], input int which);
    logic [7:0] got[$];
    got = (which == 1) ? capq : capq2;
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_c%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
    if (which == 1) capq.delete(); else capq2.delete();
  endtask

  initial begin
    logic [7:0] eq[$];
    int n;
    rx_dv = 0; rx_data = 0; rx_dv2 = 0; rx_data2 = 0; hold2 = 0;
    trk_peak = 0; peak = 0;
    grst_n = 0;
    repeat (3) @(negedge gclk);
    chk("rst_tx_dr", {31'd0, tx_dr}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_cnt", {29'd0, cnt}, 0);
    grst_n = 1;
    @(negedge gclk);

    // 1: 0x4B -> "4B\r\n" with the documented latency
    push(8'h4B);
    chk("t1_cnt_after_push", {29'd0, cnt}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    @(negedge gclk);
    chk("t1_cnt_after_pop", {29'd0, cnt}, 0);
    chk("t1_no_strobe_yet", {31'd0, tx_dr}, 0);
    @(negedge gclk);
    chk("t1_strobe", {31'd0, tx_dr}, 1);
    chk("t1_first_char", {24'd0, tx_data}, 32'h34);
    wait_idle("t1_idle_timeout", 1);
    chk("t1_busy_end", {31'd0, busy}, 0);
    eq.delete(); add_hex(eq, 8'h4B, 1);
    cmp_q("t1", eq, 1);

    // 2: two bytes two cycles apart
    peak = 0; trk_peak = 1;
    push(8'hA0); @(negedge gclk); push(8'h09);
    wait_idle("t2_idle_timeout", 1);
    trk_peak = 0;
    chk("t2_peak_in_1_2", {31'd0, (peak >= 1 && peak <= 2)}, 1);
    eq.delete(); add_hex(eq, 8'hA0, 1); add_hex(eq, 8'h09, 1);
    cmp_q("t2", eq, 1);

    // 4: push on the pop edge with a full FIFO
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5);
    chk("t4_full", {29'd0, cnt}, 4);
    n = 0;
    while (!(tx_dr && tx_data == 8'h0A) && n < 500) begin @(negedge gclk); n++; end
    chk("t4_lf_timeout", {31'd0, n < 500}, 1);
    // LF strobe at T; busy T+1..T+21, FSM IDLE at T+22, pop at T+23.
    repeat (22) @(posedge gclk);
    @(negedge gclk);
    chk("t4_still_full", {29'd0, cnt}, 4);
    push(8'hC6);
    chk("t4_cnt_after", {29'd0, cnt}, 4);
    chk("t4_no_ovf", {31'd0, ovf}, 0);
    wait_idle("t4_idle_timeout", 1);
    chk("t4_no_ovf_end", {31'd0, ovf}, 0);
    eq.delete();
    add_hex(eq, 8'hC1, 1); add_hex(eq, 8'hC2, 1); add_hex(eq, 8'hC3, 1);
    add_hex(eq, 8'hC4, 1); add_hex(eq, 8'hC5, 1); add_hex(eq, 8'hC6, 1);
    cmp_q("t4", eq, 1);

    // 3: six strobes, first popped, four buffered, sixth dropped
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
    chk("t3_cnt", {29'd0, cnt}, 4);
    chk("t3_ovf", {31'd0, ovf}, 1);
    wait_idle("t3_idle_timeout", 1);
    chk("t3_ovf_sticky", {31'd0, ovf}, 1);
    eq.delete();
    add_hex(eq, 8'h11, 1); add_hex(eq, 8'h22, 1); add_hex(eq, 8'h33, 1);
    add_hex(eq, 8'h44, 1); add_hex(eq, 8'h55, 1);
    cmp_q("t3", eq, 1);

    // 5: reset during WAIT_DONE of the second char
    push(8'h12);
    n = 0;
    while (capq.size() < 2 && n < 500) begin @(negedge gclk); n++; end
    chk("t5_second_char_timeout", {31'd0, n < 500}, 1);
    repeat (5) @(negedge gclk);
    grst_n = 0;
    #1;
    chk("t5_rst_tx_dr", {31'd0, tx_dr}, 0);
    chk("t5_rst_tx_data", {24'd0, tx_data}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_ovf", {31'd0, ovf}, 0);
    chk("t5_rst_cnt", {29'd0, cnt}, 0);
    eq.delete(); eq.push_back(8'h31); eq.push_back(8'h32);
    cmp_q("t5_pre", eq, 1);
    repeat (2) @(negedge gclk);
    grst_n = 1;
    repeat (3) @(negedge gclk);
    chk("t5_no_resume", {31'd0, busy}, 0);
    push(8'hFF);
    wait_idle("t5_idle_timeout", 1);
    eq.delete(); add_hex(eq, 8'hFF, 1);
    cmp_q("t5", eq, 1);

    // 6: no CR LF, transmitter busy for 50 cycles before the byte
    hold2 = 1;
    @(negedge gclk);
    rx_dv2 = 1; rx_data2 = 8'h3C;
    @(negedge gclk);
    rx_dv2 = 0;
    repeat (49) @(negedge gclk);
    chk("t6_no_strobe_busy", capq2.size(), 0);
    hold2 = 0;
    @(negedge gclk);
    wait_idle("t6_idle_timeout", 2);
    eq.delete(); add_hex(eq, 8'h3C, 0);
    cmp_q("t6", eq, 2);
    chk("t6_ovf", {31'd0, ovf2}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
